// File: rtl/uart_cmd_slave.sv
// UART command target: 2-byte write frames become wr_en strobes, 1-byte read frames become rd_en plus a tx response.
// Define UART_PARITY_EN for start/8 data/even parity/stop frames; leave it undefined for start/8 data/stop frames.
`timescale 1ns/1ps
module uart_cmd_slave #(
  parameter int BR        = 434,
  parameter int GAP_BITS  = 20,
  parameter int TURN_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_en,
  output logic [6:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       parity_err,
  output logic       frame_err
);
  localparam int BRW      = $clog2(BR);
  localparam int GAP_CYC  = GAP_BITS * BR;
  localparam int TURN_CYC = TURN_BITS * BR;
  localparam int LONG_MAX = (GAP_CYC > TURN_CYC) ? GAP_CYC : TURN_CYC;
  localparam int LCW      = $clog2(LONG_MAX + 1);
  localparam logic [BRW-1:0] BR_LAST   = BRW'(BR - 1);
  localparam logic [BRW-1:0] HALF_LAST = BRW'(BR / 2 - 1);
  localparam logic [LCW-1:0] GAP_LAST  = LCW'(GAP_CYC - 1);
  localparam logic [LCW-1:0] TURN_LAST = LCW'(TURN_CYC - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RX_START  = 4'd1;
  localparam logic [3:0] S_RX_DATA   = 4'd2;
  localparam logic [3:0] S_RX_PARITY = 4'd3;
  localparam logic [3:0] S_RX_STOP   = 4'd4;
  localparam logic [3:0] S_WAIT_LOW  = 4'd5;
  localparam logic [3:0] S_WR        = 4'd6;
  localparam logic [3:0] S_RD_REQ    = 4'd7;
  localparam logic [3:0] S_RD_WAIT   = 4'd8;
  localparam logic [3:0] S_TURN      = 4'd9;
  localparam logic [3:0] S_TX_START  = 4'd10;
  localparam logic [3:0] S_TX_DATA   = 4'd11;
  localparam logic [3:0] S_TX_PARITY = 4'd12;
  localparam logic [3:0] S_TX_STOP   = 4'd13;
  localparam logic [3:0] S_BREAK     = 4'd14;

  logic           rx_meta_q, rx_sync_q, rx_prev_q;
  logic [3:0]     state_q, state_d;
  logic [BRW-1:0] br_cnt_q, br_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [6:0]     addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic           byte1_q, byte1_d;
  logic [LCW-1:0] long_cnt_q, long_cnt_d;
  logic           parity_err_q, parity_err_d;
  logic           frame_err_q, frame_err_d;
  logic           rx_fall, bit_tick;

  assign rx_fall  = rx_prev_q & ~rx_sync_q;
  assign bit_tick = (br_cnt_q == BR_LAST);

  always_comb begin
    state_d      = state_q;
    br_cnt_d     = bit_tick ? '0 : br_cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    addr_d       = addr_q;
    data_d       = data_q;
    byte1_d      = byte1_q;
    long_cnt_d   = long_cnt_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      S_IDLE: if (rx_fall) begin
        state_d  = S_RX_START;
        br_cnt_d = '0;
        byte1_d  = 1'b0;
      end
      // Mid-start re-sample rejects glitches; a glitch in the inter-byte gap resumes the gap timer.
      S_RX_START: if (br_cnt_q == HALF_LAST) begin
        br_cnt_d = '0;
        if (rx_sync_q) state_d = byte1_q ? S_WAIT_LOW : S_IDLE;
        else begin
          state_d   = S_RX_DATA;
          bit_cnt_d = '0;
        end
      end
      S_RX_DATA: if (bit_tick) begin
        shift_d   = {rx_sync_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef UART_PARITY_EN
        if (bit_cnt_q == 3'd7) state_d = S_RX_PARITY;
`else
        if (bit_cnt_q == 3'd7) state_d = S_RX_STOP;
`endif
      end
      S_RX_PARITY: if (bit_tick) begin
`ifdef UART_PARITY_EN
        if (rx_sync_q != ^shift_q) begin
          parity_err_d = 1'b1;
          state_d      = S_IDLE;
        end else state_d = S_RX_STOP;
`else
        state_d = S_RX_STOP;
`endif
      end
      S_RX_STOP: if (bit_tick) begin
        if (!rx_sync_q) begin
          frame_err_d = 1'b1;
          state_d     = S_BREAK;
        end else if (byte1_q) begin
          data_d  = shift_q;
          state_d = S_WR;
        end else begin
          addr_d = shift_q[6:0];
          if (shift_q[7]) begin
            state_d    = S_WAIT_LOW;
            long_cnt_d = '0;
          end else state_d = S_RD_REQ;
        end
      end
      S_WAIT_LOW: begin
        long_cnt_d = long_cnt_q + 1'b1;
        if (rx_fall) begin
          state_d  = S_RX_START;
          br_cnt_d = '0;
          byte1_d  = 1'b1;
        end else if (long_cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      S_WR:      state_d = S_IDLE;
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        shift_d    = rd_data;
        long_cnt_d = '0;
        state_d    = S_TURN;
      end
      S_TURN: begin
        long_cnt_d = long_cnt_q + 1'b1;
        if (long_cnt_q == TURN_LAST) begin
          state_d  = S_TX_START;
          br_cnt_d = '0;
        end
      end
      S_TX_START: if (bit_tick) begin
        state_d   = S_TX_DATA;
        bit_cnt_d = '0;
      end
      // Rotate rather than shift so the full byte is back in place for the parity bit.
      S_TX_DATA: if (bit_tick) begin
        shift_d   = {shift_q[0], shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef UART_PARITY_EN
        if (bit_cnt_q == 3'd7) state_d = S_TX_PARITY;
`else
        if (bit_cnt_q == 3'd7) state_d = S_TX_STOP;
`endif
      end
      S_TX_PARITY: if (bit_tick) state_d = S_TX_STOP;
      S_TX_STOP:   if (bit_tick) state_d = S_IDLE;
      S_BREAK:     if (rx_sync_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= S_IDLE;
      br_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      byte1_q      <= 1'b0;
      long_cnt_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      state_q      <= state_d;
      br_cnt_q     <= br_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      byte1_q      <= byte1_d;
      long_cnt_q   <= long_cnt_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_TX_START:  tx = 1'b0;
      S_TX_DATA:   tx = shift_q[0];
      S_TX_PARITY: tx = ^shift_q;
      default:     tx = 1'b1;
    endcase
  end

  assign wr_en      = (state_q == S_WR);
  assign rd_en      = (state_q == S_RD_REQ);
  assign wr_addr    = addr_q;
  assign rd_addr    = addr_q;
  assign wr_data    = data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
endmodule
